controlador_memoria: RTL and testbench

CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

---
 rtl/controlador_memoria_pkg.sv | 13 +
 rtl/controlador_memoria.sv | 117 +++++++++++
 tb/tb_controlador_memoria.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_memoria_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding and default widths.
package pkg_redux;

    localparam int LARGURA_DADO_PADRAO = 8;
    localparam int LARGURA_END_PADRAO  = 8;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

endpackage

// File: rtl/controlador_memoria.sv
// Load/store controller in front of memoria_dados: fixed 3-cycle access through OCIOSO/ACESSO/RESPOSTA.
// Optional last-store forwarding compiled in with `define CONTROLADOR_MEMORIA_FWD_EN.
module controlador_memoria
    import pkg_redux::*;
#(
    parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
    parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    op_escrita,
    input  logic [LARGURA_END-1:0]  endereco_in,
    input  logic [LARGURA_DADO-1:0] dado_in,
    output logic                    pronto,
    output logic                    concluido,
    output logic [LARGURA_DADO-1:0] dado_lido,
    output logic                    mem_writeEnable,
    output logic [LARGURA_END-1:0]  mem_endereco,
    output logic [LARGURA_DADO-1:0] mem_dadoEntrada,
    input  logic [LARGURA_DADO-1:0] mem_dadoSaida
);

    estado_t                 estado, prox_estado;
    logic                    op_l;
    logic [LARGURA_END-1:0]  end_l;
    logic [LARGURA_DADO-1:0] dado_l;
    logic                    aceita;
    logic                    bypass;

`ifdef CONTROLADOR_MEMORIA_FWD_EN
    logic                    fwd_valido;
    logic [LARGURA_END-1:0]  fwd_end;
    logic [LARGURA_DADO-1:0] fwd_dado;

    always_comb begin
        bypass = aceita && !op_escrita && fwd_valido && (endereco_in == fwd_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valido <= 1'b0;
            fwd_end    <= '0;
            fwd_dado   <= '0;
        end else if (estado == RESPOSTA && op_l) begin
            fwd_valido <= 1'b1;
            fwd_end    <= end_l;
            fwd_dado   <= dado_l;
        end
    end
`else
    always_comb begin
        bypass = 1'b0;
    end
`endif

    always_comb begin
        pronto = (estado == OCIOSO);
        aceita = pronto && req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (aceita && !bypass) prox_estado = ACESSO;
            ACESSO:   prox_estado = RESPOSTA;
            RESPOSTA: prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    // Write enable is gated by reset so a store aborted in ACESSO never commits at that edge.
    always_comb begin
        mem_writeEnable = (estado == ACESSO) && op_l && !reset;
        mem_endereco    = end_l;
        mem_dadoEntrada = dado_l;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_l      <= 1'b0;
            end_l     <= '0;
            dado_l    <= '0;
            concluido <= 1'b0;
            dado_lido <= '0;
        end else begin
            concluido <= 1'b0;
            if (aceita) begin
                op_l   <= op_escrita;
                end_l  <= endereco_in;
                dado_l <= dado_in;
            end
            if (bypass) begin
`ifdef CONTROLADOR_MEMORIA_FWD_EN
                dado_lido <= fwd_dado;
`endif
                concluido <= 1'b1;
            end
            // Registered memory data is valid in RESPOSTA, one edge after the address was driven.
            if (estado == RESPOSTA) begin
                concluido <= 1'b1;
                if (!op_l) begin
                    dado_lido <= mem_dadoSaida;
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_memoria.sv
// Scoreboard bench for controlador_memoria with a behavioural memory and reference model.
module tb_controlador_memoria;

    localparam int LD   = 8;
    localparam int LE   = 8;
    localparam int MAXE = 1500;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          op_escrita;
    logic [LE-1:0] endereco_in;
    logic [LD-1:0] dado_in;
    logic          pronto;
    logic          concluido;
    logic [LD-1:0] dado_lido;
    logic          mem_writeEnable;
    logic [LE-1:0] mem_endereco;
    logic [LD-1:0] mem_dadoEntrada;
    logic [LD-1:0] mem_dadoSaida;

    always #5 clk = ~clk;

    controlador_memoria #(.LARGURA_DADO(LD), .LARGURA_END(LE)) dut (
        .clk(clk), .reset(reset), .req(req), .op_escrita(op_escrita),
        .endereco_in(endereco_in), .dado_in(dado_in), .pronto(pronto),
        .concluido(concluido), .dado_lido(dado_lido),
        .mem_writeEnable(mem_writeEnable), .mem_endereco(mem_endereco),
        .mem_dadoEntrada(mem_dadoEntrada), .mem_dadoSaida(mem_dadoSaida)
    );

    function automatic logic [LD-1:0] init_val(input int i);
        return LD'(i * 37 + 11);
    endfunction

    // Data memory with registered read
    logic [LD-1:0] ram [0:(1<<LE)-1];
    logic          ram_ok = 1'b0;
    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < (1 << LE); i++) ram[i] <= init_val(i);
            ram_ok <= 1'b1;
        end else begin
            if (mem_writeEnable) ram[mem_endereco] <= mem_dadoEntrada;
            mem_dadoSaida <= ram[mem_endereco];
        end
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endfunction

    typedef struct { int edge_n; logic [LD-1:0] dado; } exp_t;
    exp_t sbq[$];

    // Per-edge expectations for the cycle following each edge
    bit            exp_pr  [0:MAXE];
    bit            exp_we  [0:MAXE];
    bit            exp_acc [0:MAXE];
    logic [LE-1:0] exp_ea  [0:MAXE];
    logic [LD-1:0] exp_ed  [0:MAXE];

    // Reference model state
    logic [LD-1:0] ref_mem [0:(1<<LE)-1];
    int            next_free = 0;
    bit            pend = 0;
    bit            pend_op;
    logic [LE-1:0] pend_a;
    logic [LD-1:0] pend_d;
    int            pend_k;
    logic [LD-1:0] last_lido = '0;
    bit            fv = 0;
    logic [LE-1:0] fa;
    logic [LD-1:0] fd;
    int            exp_writes = 0;
    int            we_cnt = 0;
    bit            mon_on = 1'b1;

    task automatic step(input bit r, input bit q, input bit op,
                        input logic [LE-1:0] a, input logic [LD-1:0] d);
        int x;
        bit fwd;
        x = edge_cnt + 1;
        reset = r; req = q; op_escrita = op; endereco_in = a; dado_in = d;
        exp_we[x] = 1'b0;
        exp_acc[x] = 1'b0;
        if (r) begin
            if (pend) begin
                if (pend_op && x == pend_k + 1) exp_we[pend_k] = 1'b0;
                void'(sbq.pop_back());
                pend = 1'b0;
            end
            next_free = x + 1;
            last_lido = '0;
            fv = 1'b0;
        end else begin
            if (pend && pend_op && x == pend_k + 1) begin
                ref_mem[pend_a] = pend_d;
                exp_writes++;
            end
            if (pend && x == pend_k + 2) begin
                pend = 1'b0;
                if (pend_op) begin fv = 1'b1; fa = pend_a; fd = pend_d; end
            end
            if (q && x >= next_free) begin
                fwd = 1'b0;
`ifdef CONTROLADOR_MEMORIA_FWD_EN
                fwd = !op && fv && (a == fa);
`endif
                if (fwd) begin
                    last_lido = fd;
                    sbq.push_back('{x, fd});
                    next_free = x + 1;
                end else begin
                    pend = 1'b1; pend_k = x; pend_op = op; pend_a = a; pend_d = d;
                    exp_acc[x] = 1'b1; exp_ea[x] = a; exp_ed[x] = d; exp_we[x] = op;
                    if (!op) last_lido = ref_mem[a];
                    sbq.push_back('{x + 2, last_lido});
                    next_free = x + 3;
                end
            end
        end
        exp_pr[x] = (x + 1 >= next_free);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, LE'($urandom), LD'($urandom));
    endtask

    // Monitor: compares DUT against per-edge expectations and the completion scoreboard
    initial begin
        int   n;
        exp_t e;
        forever begin
            @(negedge clk);
            n = edge_cnt;
            if (mon_on && n >= 1 && n <= MAXE) begin
                chk("pronto", pronto, exp_pr[n]);
                chk("mem_writeEnable", mem_writeEnable, exp_we[n]);
                if (mem_writeEnable) we_cnt++;
                if (exp_acc[n]) begin
                    chk("mem_endereco", mem_endereco, exp_ea[n]);
                    chk("mem_dadoEntrada", mem_dadoEntrada, exp_ed[n]);
                end
                if (concluido) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_concluido", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency_edge", n, e.edge_n);
                        chk("dado_lido", dado_lido, e.dado);
                    end
                end else if (sbq.size() != 0 && sbq[0].edge_n <= n) begin
                    e = sbq.pop_front();
                    chk("missing_concluido", 0, 1);
                end
            end
        end
    end

    initial begin
        logic [LE-1:0] tbl [0:7];
        logic [LE-1:0] a;
        for (int i = 0; i < (1 << LE); i++) ref_mem[i] = init_val(i);
        tbl = '{8'h00, 8'hFF, 8'h10, 8'h20, 8'h40, 8'h41, 8'h00, 8'h00};

        step(1'b1, 1'b1, 1'b1, 8'h12, 8'h34);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_concluido", concluido, 0);
        chk("rst_dado_lido", dado_lido, 0);
        chk("rst_we", mem_writeEnable, 0);
        chk("rst_endereco", mem_endereco, 0);
        chk("rst_dadoEntrada", mem_dadoEntrada, 0);
        chk("rst_pronto", pronto, 1);

        // Store then load at 0x10
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A); idle(2);
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00); idle(3);

        // Address extremes
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h01); idle(2);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFE); idle(2);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00); idle(2);
        step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00); idle(3);

        // req held high: one acceptance every 3 cycles, the rest dropped
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i & 1), LE'(i * 5), LD'(i * 17));
        idle(3);

        // Reset during ACESSO of a store aborts it
        step(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 8'h20, 8'h00); idle(3);

        // Reset during RESPOSTA of a load aborts the pulse
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); idle(2);

        // Forwarding candidate and a neighbour address
        step(1'b0, 1'b1, 1'b1, 8'h40, 8'h33); idle(2);
        step(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h41, 8'h00); idle(3);

        for (int i = 0; i < 500; i++) begin
            a = tbl[$urandom_range(0, 7)];
            if (a == 8'h00 && $urandom_range(0, 1) == 1) a = LE'($urandom);
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
                 1'($urandom_range(0, 1)), a, LD'($urandom));
        end
        idle(6);

        mon_on = 1'b0;
        chk("queue_empty", sbq.size(), 0);
        chk("write_count", we_cnt, exp_writes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
